// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the classic multi-cycle MIPS datapath (shared ALU, one
//   unified memory, IR/MDR/A/B/ALUOut registers). Decodes R-type, addi, andi,
//   lw, sw, beq, bne and j, and drives the per-state mux selects and write
//   enables. Memory phases can stretch with wait states via mem_ready.
//
// Parameters
//   MEM_HANDSHAKE  1: FETCH/MEM_READ/MEM_WRITE wait for mem_ready
//                  0: mem_ready is ignored and treated as always 1
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   opcode[5:0]          IR[31:26], only looked at in DECODE
//   mem_ready            memory read data valid / write accepted this cycle
//   PCWrite/PCWriteCond  unconditional / conditional (Zero ^ Bne) PC load
//   Bne                  branch sense for PCWriteCond
//   IorD                 memory address select (0 = PC, 1 = ALUOut)
//   MemRead/MemWrite     memory strobes, held until mem_ready
//   IRWrite              instruction register load
//   MemtoReg, RegDst     write-back data / destination selects
//   RegWrite             register-file write enable
//   ALUSrcA, ALUSrcB     ALU operand selects
//   ALUOp                00 add, 01 sub, 10 funct, 11 and
//   PCSource             00 ALU, 01 ALUOut, 10 jump target
//   instr_done           pulse on the last cycle of every instruction
//   illegal_op           pulse in DECODE for an unsupported opcode
//   state[3:0]           current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       Bne,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       ready;

    // With the handshake disabled every memory phase completes in one cycle.
    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Next-state logic. DECODE branches on the live opcode and captures it;
    // every later state steers from op_q so the IR may change underneath.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_R_EXEC;
                    OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State and latched opcode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Output decode. Mostly Moore; IRWrite/PCWrite in FETCH and instr_done in
    // MEM_WRITE depend on mem_ready. Reset overrides everything so no write
    // enable can leak while the FSM is being pulled back to FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Bne         = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        state       = state_q;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = ready;
                PCWrite = ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI,
                    OP_BEQ, OP_BNE, OP_J: begin
                        illegal_op = 1'b0;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Bne         = (op_q == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                state = 4'd0;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            Bne         = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            state       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. A planner turns each
//   instruction (opcode, fetch wait states, memory wait states) into the
//   cycle-by-cycle inputs and the control word the datapath should see, read
//   straight from the instruction's phase list. A driver applies the inputs
//   and queues the expected words; a separate monitor pops and compares one
//   word per clock.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    // Full control word as seen by the datapath, plus the debug state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       rdy;
        out_t       exp;
    } cyc_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, Bne, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    cyc_t plan[$];
    out_t exp_q[$];
    int   checks;
    int   errors;
    int   cycle_no;

    multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Bne(Bne), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
    endfunction

    function automatic out_t stOut(input int s);
        out_t o;
        o = '0;
        o.state = 4'(s);
        return o;
    endfunction

    function automatic out_t fetchOut();
        out_t o;
        o = stOut(0);
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        return o;
    endfunction

    function automatic logic [5:0] fillOp(input int filler);
        if (filler < 0) return 6'($urandom);
        return 6'(filler);
    endfunction

    function automatic logic rndBit();
        return 1'($urandom);
    endfunction

    task automatic addCycle(input logic r, input logic [5:0] opc,
                            input logic rdy, input out_t e);
        cyc_t c;
        c.rst = r;
        c.opc = opc;
        c.rdy = rdy;
        c.exp = e;
        plan.push_back(c);
    endtask

    task automatic addReset(input int n);
        for (int i = 0; i < n; i++) addCycle(1'b1, 6'($urandom), rndBit(), '0);
    endtask

    // Expand one instruction into its phases. filler < 0 puts random junk on
    // opcode outside DECODE; otherwise that fixed value is held there.
    task automatic buildInstr(input logic [5:0] op, input int fetch_wait,
                              input int mem_wait, input int filler);
        out_t o;
        for (int i = 0; i < fetch_wait; i++) addCycle(1'b0, fillOp(filler), 1'b0, fetchOut());
        o = fetchOut();
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        addCycle(1'b0, fillOp(filler), 1'b1, o);

        o = stOut(1);
        o.alu_src_b = 2'b11;
        if (!isLegal(op)) begin
            o.illegal_op = 1'b1;
            o.instr_done = 1'b1;
            addCycle(1'b0, op, rndBit(), o);
            return;
        end
        addCycle(1'b0, op, rndBit(), o);

        if (op == 6'h23 || op == 6'h2B) begin
            o = stOut(2);
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
            if (op == 6'h23) begin
                o = stOut(3);
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
                for (int i = 0; i < mem_wait; i++) addCycle(1'b0, fillOp(filler), 1'b0, o);
                addCycle(1'b0, fillOp(filler), 1'b1, o);
                o = stOut(4);
                o.mem_to_reg = 1'b1;
                o.reg_write  = 1'b1;
                o.instr_done = 1'b1;
                addCycle(1'b0, fillOp(filler), rndBit(), o);
            end else begin
                o = stOut(5);
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
                for (int i = 0; i < mem_wait; i++) addCycle(1'b0, fillOp(filler), 1'b0, o);
                o.instr_done = 1'b1;
                addCycle(1'b0, fillOp(filler), 1'b1, o);
            end
        end else if (op == 6'h00) begin
            o = stOut(6);
            o.alu_src_a = 1'b1;
            o.alu_op    = 2'b10;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
            o = stOut(7);
            o.reg_dst    = 1'b1;
            o.reg_write  = 1'b1;
            o.instr_done = 1'b1;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
        end else if (op == 6'h08 || op == 6'h0C) begin
            o = stOut(8);
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            o.alu_op    = (op == 6'h0C) ? 2'b11 : 2'b00;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
            o = stOut(9);
            o.reg_write  = 1'b1;
            o.instr_done = 1'b1;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
        end else if (op == 6'h04 || op == 6'h05) begin
            o = stOut(10);
            o.alu_src_a     = 1'b1;
            o.alu_op        = 2'b01;
            o.pc_write_cond = 1'b1;
            o.pc_source     = 2'b01;
            o.bne           = (op == 6'h05);
            o.instr_done    = 1'b1;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
        end else begin
            o = stOut(11);
            o.pc_write   = 1'b1;
            o.pc_source  = 2'b10;
            o.instr_done = 1'b1;
            addCycle(1'b0, fillOp(filler), rndBit(), o);
        end
    endtask

    // Cut the instruction just planned after keep cycles and pull reset.
    task automatic truncateWithReset(input int start, input int keep, input int rst_cycles);
        while (plan.size() > start + keep) void'(plan.pop_back());
        addReset(rst_cycles);
    endtask

    function automatic logic [5:0] randomOp();
        logic [5:0] legal [8];
        logic [5:0] op;
        legal = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
        if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (isLegal(op));
            return op;
        end
        return legal[$urandom_range(0, 7)];
    endfunction

    // Drive the planned inputs just after each rising edge and queue the
    // expected control word for that cycle.
    task automatic applyStimulus();
        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            reset     = plan[i].rst;
            opcode    = plan[i].opc;
            mem_ready = plan[i].rdy;
            exp_q.push_back(plan[i].exp);
        end
    endtask

    // Compare the DUT's control word on the falling edge against the queue.
    task automatic checkOutput();
        out_t act;
        out_t exp;
        act = {PCWrite, PCWriteCond, Bne, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, state};
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL ctrl_word cycle=%0d state act=%0d exp=%0d word act=%h exp=%h",
                     cycle_no, act.state, exp.state, act, exp);
        end
        cycle_no++;
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        int start;
        int waited;
        checks    = 0;
        errors    = 0;
        cycle_no  = 0;
        reset     = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;

        // Reset, then a fetch that waits two cycles, fed into an lw.
        addReset(3);
        buildInstr(6'h23, 2, 0, -1);
        // lw with no wait states.
        buildInstr(6'h23, 0, 0, -1);
        // sw held three cycles in MEM_WRITE.
        buildInstr(6'h2B, 0, 3, -1);
        // Branches and jump.
        buildInstr(6'h05, 0, 0, -1);
        buildInstr(6'h04, 0, 0, -1);
        buildInstr(6'h02, 0, 0, -1);
        // IR changes to lw after decoding an R-type; then andi and addi.
        buildInstr(6'h00, 0, 0, 6'h23);
        buildInstr(6'h0C, 0, 0, 6'h00);
        buildInstr(6'h08, 1, 0, -1);
        // Illegal opcode, then reset in the middle of a MEM_READ wait.
        buildInstr(6'h3F, 0, 0, -1);
        start = plan.size();
        buildInstr(6'h23, 0, 3, -1);
        truncateWithReset(start, 5, 1);
        buildInstr(6'h00, 0, 0, -1);

        // Random instruction stream with wait states and occasional resets.
        for (int n = 0; n < 200; n++) begin
            int fw;
            int mw;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mw = $urandom_range(0, 3);
            start = plan.size();
            buildInstr(randomOp(), fw, mw, -1);
            if ($urandom_range(0, 11) == 0)
                truncateWithReset(start, $urandom_range(1, plan.size() - start),
                                  $urandom_range(1, 2));
        end

        $display("[TB] planned %0d cycles", plan.size());
        applyStimulus();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending act=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
